// File: rtl/fp32_pkg.sv
// Shared single-precision FPU constants and types.
// Used by the divider and its rounding stage.
package fp32_pkg;

    localparam int          EXP_BIAS = 127;
    localparam int          EXP_W    = 8;
    localparam int          MANT_W   = 23;
    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        RNE = 2'b00,
        RTZ = 2'b01,
        RUP = 2'b10,
        RDN = 2'b11
    } round_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DIVIDE = 2'b01,
        ROUND  = 2'b10,
        DONE   = 2'b11
    } state_t;

endpackage

// File: rtl/fp32_divider_if.sv
// Request/response bundle of the fp32 divider.
// master = requester, slave = divider.
interface fp32_divider_if;

    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  round_mode;
    logic        busy;
    logic        done;
    logic        errorDiv;
    logic        overflowDiv;
    logic [31:0] resultDiv;

    modport master (
        output start, A, B, round_mode,
        input  busy, done, errorDiv, overflowDiv, resultDiv
    );

    modport slave (
        input  start, A, B, round_mode,
        output busy, done, errorDiv, overflowDiv, resultDiv
    );

endinterface

// File: rtl/fp32_round.sv
// Combinational IEEE 754 single rounding and packing.
// Shared between the FPU divider and multiplier.
module fp32_round
    import fp32_pkg::*;
(
    input  logic              i_sign,
    input  logic signed [9:0] i_exp,
    input  logic [23:0]       i_mant,
    input  logic              i_guard,
    input  logic              i_sticky,
    input  round_mode_t       i_rm,
    output logic [31:0]       o_result,
    output logic              o_overflow,
    output logic              o_underflow
);

    logic              w_inc;
    logic [24:0]       w_sum;
    logic signed [9:0] w_exp;
    logic [22:0]       w_frac;

    // Round increment decision, mantissa carry and final packing
    always_comb begin
        w_inc = 1'b0;
        unique case (i_rm)
            RNE: w_inc = i_guard & (i_sticky | i_mant[0]);
            RTZ: w_inc = 1'b0;
            RUP: w_inc = ~i_sign & (i_guard | i_sticky);
            RDN: w_inc = i_sign & (i_guard | i_sticky);
        endcase

        w_sum  = {1'b0, i_mant} + {24'd0, w_inc};
        w_exp  = w_sum[24] ? (i_exp + 10'sd1) : i_exp;
        w_frac = w_sum[24] ? w_sum[23:1] : w_sum[22:0];

        o_overflow  = 1'b0;
        o_underflow = 1'b0;
        if (w_exp >= 10'sd255) begin
            o_overflow = 1'b1;
            o_result   = {i_sign, EXP_MAX, 23'h0};
        end else if (w_exp <= 10'sd0) begin
            o_underflow = 1'b1;
            o_result    = 32'h0;
        end else begin
            o_result = {i_sign, w_exp[7:0], w_frac};
        end
    end

endmodule

// File: rtl/fp32_divider.sv
// Iterative restoring radix-2 IEEE 754 single divider.
// Optional macro FP_DIV_EARLY_OUT_EN: power-of-two divisors skip the loop.
module fp32_divider
    import fp32_pkg::*;
#(
    parameter int ITER_PER_CYCLE = 1
)
(
    input  logic           clk,
    input  logic           reset,
    fp32_divider_if.slave  bus
);

    generate
        if (ITER_PER_CYCLE != 1 && ITER_PER_CYCLE != 2) begin : g_bad_iter
            $error("ITER_PER_CYCLE must be 1 or 2");
        end
    endgenerate

    localparam logic [4:0] LOOP_LAST = 5'(26 / ITER_PER_CYCLE - 1);

    state_t            r_state;
    state_t            w_state_n;
    logic [4:0]        r_cnt;
    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [23:0]       r_mb;
    logic [25:0]       r_rem;
    logic [25:0]       r_q;
    round_mode_t       r_rm;
    logic              r_spec;
    logic [31:0]       r_spec_res;
    logic              r_spec_err;
    logic [31:0]       r_result;
    logic              r_err;
    logic              r_ovf;

    logic [7:0]        w_ea;
    logic [7:0]        w_eb;
    logic              w_za;
    logic              w_zb;
    logic              w_infa;
    logic              w_infb;
    logic              w_nan;
    logic              w_special;
    logic              w_early;
    logic              w_sign;
    logic signed [9:0] w_exp_q;
    logic [31:0]       w_spec_res;
    logic              w_spec_err;
    logic [25:0]       w_rem_n;
    logic [25:0]       w_q_n;
    logic              w_msb;
    logic [23:0]       w_mant;
    logic              w_guard;
    logic              w_sticky;
    logic signed [9:0] w_exp_n;
    logic [31:0]       w_rnd_res;
    logic              w_rnd_ovf;
    logic              w_rnd_unf;

    assign w_ea    = bus.A[30:23];
    assign w_eb    = bus.B[30:23];
    assign w_za    = (w_ea == 8'h00);
    assign w_zb    = (w_eb == 8'h00);
    assign w_infa  = (w_ea == EXP_MAX) && (bus.A[22:0] == 23'h0);
    assign w_infb  = (w_eb == EXP_MAX) && (bus.B[22:0] == 23'h0);
    assign w_nan   = ((w_ea == EXP_MAX) && (bus.A[22:0] != 23'h0))
                   || ((w_eb == EXP_MAX) && (bus.B[22:0] != 23'h0))
                   || (w_za && w_zb) || (w_infa && w_infb);
    assign w_special = w_za || w_zb
                     || (w_ea == EXP_MAX) || (w_eb == EXP_MAX);
    assign w_sign  = bus.A[31] ^ bus.B[31];
    assign w_exp_q = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb})
                   + 10'(EXP_BIAS);

`ifdef FP_DIV_EARLY_OUT_EN
    assign w_early = ~w_special && (bus.B[22:0] == 23'h0);
`else
    assign w_early = 1'b0;
`endif

    // Special-operand result, resolved in priority order
    always_comb begin
        w_spec_res = 32'h0;
        w_spec_err = 1'b0;
        if (w_nan) begin
            w_spec_res = QNAN;
            w_spec_err = 1'b1;
        end else if (w_zb && !w_infa) begin
            w_spec_res = {w_sign, EXP_MAX, 23'h0};
            w_spec_err = 1'b1;
        end else if (w_infa) begin
            w_spec_res = {w_sign, EXP_MAX, 23'h0};
        end else begin
            w_spec_res = {w_sign, 31'h0};
        end
    end

    // Restoring division steps resolved this cycle
    always_comb begin
        w_rem_n = r_rem;
        w_q_n   = r_q;
        for (int i = 0; i < ITER_PER_CYCLE; i++) begin
            if (w_rem_n >= {2'b00, r_mb}) begin
                w_rem_n = w_rem_n - {2'b00, r_mb};
                w_q_n   = {w_q_n[24:0], 1'b1};
            end else begin
                w_q_n   = {w_q_n[24:0], 1'b0};
            end
            w_rem_n = {w_rem_n[24:0], 1'b0};
        end
    end

    // Normalise the quotient and extract guard/sticky
    always_comb begin
        w_msb    = r_q[25];
        w_mant   = w_msb ? r_q[25:2] : r_q[24:1];
        w_guard  = w_msb ? r_q[1] : r_q[0];
        w_sticky = w_msb ? (r_q[0] | (|r_rem)) : (|r_rem);
        w_exp_n  = w_msb ? r_exp : (r_exp - 10'sd1);
    end

    fp32_round u_round (
        .i_sign      (r_sign),
        .i_exp       (w_exp_n),
        .i_mant      (w_mant),
        .i_guard     (w_guard),
        .i_sticky    (w_sticky),
        .i_rm        (r_rm),
        .o_result    (w_rnd_res),
        .o_overflow  (w_rnd_ovf),
        .o_underflow (w_rnd_unf)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_n;
    end

    // FSM next-state logic
    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.start)
                    w_state_n = (w_special || w_early) ? ROUND : DIVIDE;
            end
            DIVIDE: begin
                if (r_cnt == 5'd0) w_state_n = ROUND;
            end
            ROUND:   w_state_n = DONE;
            DONE:    w_state_n = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= 5'd0;
            r_sign     <= 1'b0;
            r_exp      <= 10'sd0;
            r_mb       <= 24'h0;
            r_rem      <= 26'h0;
            r_q        <= 26'h0;
            r_rm       <= RNE;
            r_spec     <= 1'b0;
            r_spec_res <= 32'h0;
            r_spec_err <= 1'b0;
            r_result   <= 32'h0;
            r_err      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_cnt      <= LOOP_LAST;
                        r_sign     <= w_sign;
                        r_exp      <= w_exp_q;
                        r_mb       <= {1'b1, bus.B[22:0]};
                        r_rm       <= round_mode_t'(bus.round_mode);
                        r_spec     <= w_special;
                        r_spec_res <= w_spec_res;
                        r_spec_err <= w_spec_err;
                        if (w_early) begin
                            r_rem <= 26'h0;
                            r_q   <= {1'b1, bus.A[22:0], 2'b00};
                        end else begin
                            r_rem <= {3'b001, bus.A[22:0]};
                            r_q   <= 26'h0;
                        end
                    end
                end
                DIVIDE: begin
                    r_rem <= w_rem_n;
                    r_q   <= w_q_n;
                    r_cnt <= r_cnt - 5'd1;
                end
                ROUND: begin
                    if (r_spec) begin
                        r_result <= r_spec_res;
                        r_err    <= r_spec_err;
                        r_ovf    <= 1'b0;
                    end else begin
                        r_result <= w_rnd_res;
                        r_err    <= w_rnd_unf;
                        r_ovf    <= w_rnd_ovf;
                    end
                end
                DONE: begin
                end
            endcase
        end
    end

    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = (r_state == DONE);
    assign bus.resultDiv   = r_result;
    assign bus.errorDiv    = r_err;
    assign bus.overflowDiv = r_ovf;

endmodule

// File: tb/tb_fp32_divider.sv
// Self-checking bench for fp32_divider: directed cases, handshake,
// reset abort and randomized operands against an integer reference.
module tb_fp32_divider;

    localparam int ITER = 1;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fp32_divider_if bus ();

    fp32_divider #(.ITER_PER_CYCLE(ITER)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic is_special(input logic [31:0] a,
                                        input logic [31:0] b);
        return (a[30:23] == 8'd0) || (a[30:23] == 8'hFF)
            || (b[30:23] == 8'd0) || (b[30:23] == 8'hFF);
    endfunction

    // Edges from the accepting edge (counted as 1) to the done cycle
    function automatic int exp_lat(input logic [31:0] a,
                                   input logic [31:0] b);
        if (is_special(a, b)) return 2;
`ifdef FP_DIV_EARLY_OUT_EN
        if (b[22:0] == 23'd0) return 2;
`endif
        return 2 + 26 / ITER;
    endfunction

    // Reference quotient: returns {errorDiv, overflowDiv, resultDiv}
    function automatic logic [33:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [1:0] rm);
        logic sgn, za, zb, ia, ib, na, nb, up, inexact;
        longint ma, mb, num, q, r, lost, half, mant;
        int e, sh;
        sgn = a[31] ^ b[31];
        za = (a[30:23] == 0);
        zb = (b[30:23] == 0);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        if (na || nb || (za && zb) || (ia && ib))
            return {2'b10, 32'h7FC00000};
        if (zb && !ia) return {2'b10, sgn, 8'hFF, 23'h0};
        if (ia) return {2'b00, sgn, 8'hFF, 23'h0};
        if (za || ib) return {2'b00, sgn, 31'h0};
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        num = ma << 38;
        q = num / mb;
        r = num % mb;
        e = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (q >= (longint'(1) << 38)) sh = 15;
        else begin
            sh = 14;
            e = e - 1;
        end
        mant = q >> sh;
        lost = q & ((longint'(1) << sh) - 1);
        half = longint'(1) << (sh - 1);
        inexact = (lost != 0) || (r != 0);
        case (rm)
            2'b00: up = (lost > half) || ((lost == half) && (r != 0))
                      || ((lost == half) && (r == 0) && mant[0]);
            2'b01: up = 1'b0;
            2'b10: up = !sgn && inexact;
            default: up = sgn && inexact;
        endcase
        if (up) mant = mant + 1;
        if (mant == (longint'(1) << 24)) begin
            mant = longint'(1) << 23;
            e = e + 1;
        end
        if (e >= 255) return {2'b01, sgn, 8'hFF, 23'h0};
        if (e <= 0) return {2'b10, 32'h0};
        return {2'b00, sgn, 8'(e), mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 11))
            0: v[30:0] = 31'h0;
            1: v[30:0] = {8'hFF, 23'h0};
            2: v[30:0] = {8'hFF, 23'h400001};
            3: v[30:23] = 8'($urandom_range(1, 254));
            4: v[30:0] = {8'($urandom_range(100, 154)), 23'h0};
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] rm,
                          input logic [33:0] expv);
        int n;
        logic busy_ok;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.round_mode = rm;
        @(posedge clk);
        n = 1;
        #1;
        bus.start = 1'b0;
        busy_ok = bus.busy;
        while (!bus.done && n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (!bus.busy) busy_ok = 1'b0;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat(a, b)));
        chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, "_res"}, bus.resultDiv, expv[31:0]);
        chk({tag, "_err"}, {31'd0, bus.errorDiv}, {31'd0, expv[33]});
        chk({tag, "_ovf"}, {31'd0, bus.overflowDiv}, {31'd0, expv[32]});
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    logic [31:0] da [9] = '{32'h40C00000, 32'h3F800000, 32'h3F800000,
                            32'h3F800000, 32'h3F800000, 32'h00000000,
                            32'h7F7FFFFF, 32'h00800000, 32'hBF800000};
    logic [31:0] db [9] = '{32'h40000000, 32'h40400000, 32'h40400000,
                            32'hC0400000, 32'h00000000, 32'h00000000,
                            32'h3F000000, 32'h40000000, 32'h40800000};
    logic [1:0]  dm [9] = '{2'd0, 2'd0, 2'd1, 2'd3, 2'd0, 2'd0,
                            2'd0, 2'd0, 2'd0};
    logic [33:0] de [9] = '{{2'b00, 32'h40400000}, {2'b00, 32'h3EAAAAAB},
                            {2'b00, 32'h3EAAAAAA}, {2'b00, 32'hBEAAAAAB},
                            {2'b10, 32'h7F800000}, {2'b10, 32'h7FC00000},
                            {2'b01, 32'h7F800000}, {2'b10, 32'h00000000},
                            {2'b00, 32'hBE800000}};

    initial begin
        logic [31:0] ra, rb, first_res;
        logic [1:0]  rrm;
        int first_cyc, k, ndone;
        logic seen;

        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.A = 32'h0;
        bus.B = 32'h0;
        bus.round_mode = 2'b00;
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_res", bus.resultDiv, 32'h0);
        chk("rst_flags", {30'd0, bus.errorDiv, bus.overflowDiv}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++)
            run_op($sformatf("dir%0d", i), da[i], db[i], dm[i], de[i]);

        // start held high; operands change mid-operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 32'h3F800000;
        bus.B = 32'h40400000;
        bus.round_mode = 2'b00;
        seen = 1'b0;
        first_cyc = 0;
        first_res = 32'h0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 5) begin
                bus.A = 32'h40C00000;
                bus.B = 32'h40000000;
            end
            if (bus.done && !seen) begin
                seen = 1'b1;
                first_cyc = c;
                first_res = bus.resultDiv;
            end
        end
        bus.start = 1'b0;
        chk("hold_seen", {31'd0, seen}, 32'd1);
        chk("hold_lat", 32'(first_cyc), 32'(2 + 26 / ITER));
        chk("hold_res", first_res, 32'h3EAAAAAB);
        k = 0;
        while (bus.busy && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("hold_idle", {31'd0, bus.busy}, 32'd0);

        // reset in the middle of DIVIDE
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = 32'h3F800000;
        bus.B = 32'h40400000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_res", bus.resultDiv, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        chk("abort_nodone", 32'(ndone), 32'd0);

        // randomized operands against the reference model
        for (int i = 0; i < 60; i++) begin
            ra = rand_fp();
            rb = rand_fp();
            rrm = 2'($urandom_range(0, 3));
            run_op($sformatf("rnd%0d", i), ra, rb, rrm, model(ra, rb, rrm));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
